aes_cbc_arbiter: RTL and testbench
==================================

AES_CBC_ARBITER -- requirements
Module: aes_cbc_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of requester channels (legal 2..4).
REQ-002 SHALL have parameter AXIS_WIDTH, default 8, tdata width of every stream port (multiple of 8).
REQ-003 SHALL have port Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port S_axis  axis_if.slave [NUM_CH]  requester message streams (tdata/tkeep/tuser/tlast/tvalid/tready).
REQ-006 SHALL have port M_axis  axis_if.master [NUM_CH]  result streams returned to requesters.
REQ-007 SHALL have port Eng_m_axis  axis_if.master  1  message stream forwarded to the shared AES256-CBC engine.
REQ-008 SHALL have port Eng_s_axis  axis_if.slave  1  result stream from the shared engine.
REQ-009 SHALL have port Grant  output  NUM_CH  one-hot owner of the engine; all-zero when idle.
REQ-010 SHALL have port Busy  output  1  high whenever state is not ST_IDLE.

Function
REQ-011 SHALL implement states ST_IDLE, ST_FWD, ST_DRAIN, one-hot encoded.
REQ-012 ST_IDLE: if any S_axis[i].tvalid, SHALL grant the first requesting channel searching upward from rr_ptr+1 (wrapping modulo NUM_CH), register Grant, go to ST_FWD; no data passes in ST_IDLE (1-cycle arbitration latency).
REQ-013 ST_FWD: SHALL combinationally connect granted S_axis to Eng_m_axis (tdata, tkeep, tuser, tlast, tvalid forward; tready back) and Eng_s_axis to granted M_axis (all fields forward; tready back).
REQ-014 ST_FWD: on granted S_axis handshake with tlast=1, SHALL go to ST_DRAIN.
REQ-015 ST_DRAIN: SHALL hold granted S_axis.tready=0 and Eng_m_axis.tvalid=0; return path stays connected as in REQ-013.
REQ-016 In ST_FWD or ST_DRAIN, an Eng_s_axis handshake with tlast=1 SHALL set rr_ptr to the granted index, clear Grant, and go to ST_IDLE.
REQ-017 An output-tlast handshake while still in ST_FWD (engine protocol error) SHALL also return to ST_IDLE per REQ-016.
REQ-018 Non-granted channels SHALL see S_axis.tready=0 and M_axis tvalid/tdata/tkeep/tlast/tuser=0 at all times.
REQ-019 When Grant is zero, Eng_m_axis fields SHALL be 0 and Eng_s_axis.tready SHALL be 0.
REQ-020 Grant SHALL be constant from arbitration until the return-path tlast handshake; requests arriving meanwhile wait.
REQ-021 Forwarding SHALL add zero cycles of latency and no buffering in both directions.

Reset
REQ-022 Rst high SHALL force ST_IDLE, Grant=0, Busy=0, rr_ptr=NUM_CH-1 (channel 0 wins first), all outputs to 0, immediately and regardless of Clk.
REQ-023 Reset mid-message SHALL abandon the message without flushing; the engine is reset from the same Rst.

Configuration
REQ-024 With macro AES_ARB_STATS_EN defined, SHALL add output Msg_cnt [NUM_CH][15:0], per channel incremented on each REQ-016 release, wrapping 16'hFFFF->0, reset to 0.
REQ-025 Without AES_ARB_STATS_EN, Msg_cnt and its counters SHALL not exist; all other behaviour identical.

Structure
REQ-026 Package aes_arb_pkg SHALL hold the state enum typedef and constant AES_ARB_MAX_CH=4.
REQ-027 Round-robin search SHALL live in sub-module aes_rr_picker (inputs request vector, rr_ptr; output one-hot pick).

Verification
REQ-028 Reset, then S_axis[0] sends 32-byte key, 16-byte IV, 16-byte text (64 beats, tlast on beat 64, AXIS_WIDTH=8) -> Grant=2'b01 one cycle later, 64 beats forwarded unchanged, 16 return beats reach M_axis[0] only, Grant=0 after return tlast.
REQ-029 Both channels assert tvalid in the same cycle after reset -> channel 0 served first, channel 1 granted on the cycle after channel 0's return tlast.
REQ-030 Channel 0 requests again while channel 1 is granted -> no channel-0 beat accepted until channel 1 releases; next grant goes to channel 0.
REQ-031 In ST_DRAIN, channel 1 holds tvalid=1 -> S_axis[1].tready stays 0 and Eng_m_axis.tvalid stays 0 until release.
REQ-032 Engine back-pressure: M_axis[0].tready toggled 1/0 each cycle -> Eng_s_axis.tready mirrors it, no beat lost or duplicated.
REQ-033 Rst asserted mid-ST_FWD -> Grant, Busy, all tvalid/tready outputs 0 before next Clk edge; with AES_ARB_STATS_EN, Msg_cnt[0]=1 after REQ-028 and 0 after reset.

Source files
------------

// File: rtl/aes_arb_pkg.sv
// Shared constants and FSM state type for the AES256-CBC engine arbiter.
package aes_arb_pkg;

  localparam int AES_ARB_MAX_CH = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_FWD   = 3'b010,
    ST_DRAIN = 3'b100
  } arb_state_t;

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle (tdata/tkeep/tuser/tlast/tvalid/tready) with master/slave modports.
interface axis_if #(
  parameter int W = 8,
  parameter int U = 1
);
  logic [W-1:0]   tdata;
  logic [W/8-1:0] tkeep;
  logic [U-1:0]   tuser;
  logic           tlast;
  logic           tvalid;
  logic           tready;

  modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/aes_rr_picker.sv
// Combinational round-robin pick: first requester above i_ptr, wrapping; one-hot result.
module aes_rr_picker #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_pick
);

  always_comb begin
    logic w_found;
    w_found = 1'b0;
    o_pick  = '0;
    // k = 1 first so the previous owner has the lowest priority
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (!w_found && i_req[j] && (j == (int'(i_ptr) + k) % NUM_CH)) begin
          o_pick[j] = 1'b1;
          w_found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/aes_cbc_arbiter.sv
// Shares one AES256-CBC engine among NUM_CH streams; 1-cycle grant, zero-latency unbuffered forwarding.
// Define AES_ARB_STATS_EN to add per-channel completed-message counters (Msg_cnt).
module aes_cbc_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int AXIS_WIDTH = 8
) (
  input  logic              Clk,
  input  logic              Rst,
  axis_if.slave             S_axis [NUM_CH],
  axis_if.master            M_axis [NUM_CH],
  axis_if.master            Eng_m_axis,
  axis_if.slave             Eng_s_axis,
  output logic [NUM_CH-1:0] Grant,
  output logic              Busy
`ifdef AES_ARB_STATS_EN
  ,
  output logic [15:0]       Msg_cnt [NUM_CH]
`endif
);

  localparam int PTR_W  = $clog2(AES_ARB_MAX_CH);
  localparam int KEEP_W = AXIS_WIDTH / 8;

  arb_state_t        r_state;
  logic [NUM_CH-1:0] r_grant;
  logic [PTR_W-1:0]  r_ptr;
  logic              r_busy;

  logic [AXIS_WIDTH-1:0] w_s_tdata [NUM_CH];
  logic [KEEP_W-1:0]     w_s_tkeep [NUM_CH];
  logic [NUM_CH-1:0]     w_s_tuser, w_s_tlast, w_s_tvalid, w_m_tready, w_pick;

  logic [AXIS_WIDTH-1:0] w_sel_tdata;
  logic [KEEP_W-1:0]     w_sel_tkeep;
  logic                  w_sel_tuser, w_sel_tlast, w_sel_tvalid, w_sel_m_tready;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic                  w_fwd, w_in_last, w_ret_last;

  aes_rr_picker #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_picker (
    .i_req  (w_s_tvalid),
    .i_ptr  (r_ptr),
    .o_pick (w_pick)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_s_tdata[i]  = S_axis[i].tdata;
    assign w_s_tkeep[i]  = S_axis[i].tkeep;
    assign w_s_tuser[i]  = S_axis[i].tuser;
    assign w_s_tlast[i]  = S_axis[i].tlast;
    assign w_s_tvalid[i] = S_axis[i].tvalid;
    assign w_m_tready[i] = M_axis[i].tready;

    assign S_axis[i].tready = r_grant[i] & w_fwd & Eng_m_axis.tready;
    assign M_axis[i].tvalid = r_grant[i] & Eng_s_axis.tvalid;
    assign M_axis[i].tdata  = r_grant[i] ? Eng_s_axis.tdata : '0;
    assign M_axis[i].tkeep  = r_grant[i] ? Eng_s_axis.tkeep : '0;
    assign M_axis[i].tuser  = r_grant[i] ? Eng_s_axis.tuser : '0;
    assign M_axis[i].tlast  = r_grant[i] & Eng_s_axis.tlast;
  end

  // One-hot grant mux; everything reads zero while nobody owns the engine.
  always_comb begin
    w_sel_tdata    = '0;
    w_sel_tkeep    = '0;
    w_sel_tuser    = 1'b0;
    w_sel_tlast    = 1'b0;
    w_sel_tvalid   = 1'b0;
    w_sel_m_tready = 1'b0;
    w_gnt_idx      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_grant[i]) begin
        w_sel_tdata    = w_s_tdata[i];
        w_sel_tkeep    = w_s_tkeep[i];
        w_sel_tuser    = w_s_tuser[i];
        w_sel_tlast    = w_s_tlast[i];
        w_sel_tvalid   = w_s_tvalid[i];
        w_sel_m_tready = w_m_tready[i];
        w_gnt_idx      = PTR_W'(i);
      end
    end
  end

  assign w_fwd      = (r_state == ST_FWD);
  assign w_in_last  = w_fwd & w_sel_tvalid & w_sel_tlast & Eng_m_axis.tready;
  assign w_ret_last = Eng_s_axis.tvalid & w_sel_m_tready & Eng_s_axis.tlast;

  assign Eng_m_axis.tdata  = w_sel_tdata;
  assign Eng_m_axis.tkeep  = w_sel_tkeep;
  assign Eng_m_axis.tuser  = w_sel_tuser;
  assign Eng_m_axis.tlast  = w_sel_tlast;
  assign Eng_m_axis.tvalid = w_fwd & w_sel_tvalid;
  assign Eng_s_axis.tready = w_sel_m_tready;

  assign Grant = r_grant;
  assign Busy  = r_busy;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= PTR_W'(NUM_CH - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_pick) begin
            r_grant <= w_pick;
            r_busy  <= 1'b1;
            r_state <= ST_FWD;
          end
        end
        ST_FWD, ST_DRAIN: begin
          // Result tlast releases even mid-request: a misbehaving engine must not wedge the arbiter.
          if (w_ret_last) begin
            r_ptr   <= w_gnt_idx;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_in_last) begin
            r_state <= ST_DRAIN;
          end
        end
        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef AES_ARB_STATS_EN
  logic [15:0] r_msg_cnt [NUM_CH];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NUM_CH; i++) r_msg_cnt[i] <= '0;
    end else if (w_ret_last) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (r_grant[i]) r_msg_cnt[i] <= r_msg_cnt[i] + 16'd1;
      end
    end
  end

  assign Msg_cnt = r_msg_cnt;
`endif

endmodule

// File: tb/tb_aes_cbc_arbiter.sv
// Directed bench for aes_cbc_arbiter: two requesters plus a scripted engine on the shared ports.
module tb_aes_cbc_arbiter;
  localparam int N = 2;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_if #(.W(W)) s_if [N] ();
  axis_if #(.W(W)) m_if [N] ();
  axis_if #(.W(W)) eng_m ();
  axis_if #(.W(W)) eng_s ();

  logic [N-1:0] grant;
  logic         busy;
`ifdef AES_ARB_STATS_EN
  logic [15:0]  msg_cnt [N];
`endif

  logic [W-1:0] s_tdata [N];
  logic [W-1:0] m_tdata [N];
  logic [N-1:0] s_tvalid, s_tlast, s_tuser, s_tready;
  logic [N-1:0] m_tvalid, m_tlast, m_tready;
  logic         e_rdy, e_vld, e_last;
  logic [W-1:0] e_dat;

  for (genvar i = 0; i < N; i++) begin : g_if
    assign s_if[i].tdata  = s_tdata[i];
    assign s_if[i].tkeep  = '1;
    assign s_if[i].tuser  = s_tuser[i];
    assign s_if[i].tlast  = s_tlast[i];
    assign s_if[i].tvalid = s_tvalid[i];
    assign s_tready[i]    = s_if[i].tready;
    assign m_if[i].tready = m_tready[i];
    assign m_tvalid[i]    = m_if[i].tvalid;
    assign m_tdata[i]     = m_if[i].tdata;
    assign m_tlast[i]     = m_if[i].tlast;
  end

  assign eng_m.tready = e_rdy;
  assign eng_s.tdata  = e_dat;
  assign eng_s.tkeep  = '1;
  assign eng_s.tuser  = 1'b0;
  assign eng_s.tlast  = e_last;
  assign eng_s.tvalid = e_vld;

  aes_cbc_arbiter #(.NUM_CH(N), .AXIS_WIDTH(W)) dut (
    .Clk        (clk),
    .Rst        (rst),
    .S_axis     (s_if),
    .M_axis     (m_if),
    .Eng_m_axis (eng_m),
    .Eng_s_axis (eng_s),
    .Grant      (grant),
    .Busy       (busy)
`ifdef AES_ARB_STATS_EN
    ,
    .Msg_cnt    (msg_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] msg0(int k);
    return W'(k * 13 + 1);
  endfunction

  function automatic logic [W-1:0] ret0(int j);
    return W'(192 + j);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   j, errs, derr, cyc;
    logic t;
    logic [W-1:0] got [$];

    s_tdata[0] = msg0(0);
    s_tdata[1] = 8'hA5;
    s_tvalid   = 2'b11;
    s_tlast    = '0;
    s_tuser    = '0;
    m_tready   = '0;
    e_rdy      = 1'b1;
    e_vld      = 1'b0;
    e_last     = 1'b0;
    e_dat      = '0;

    // Reset state with both channels already requesting
    @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_s_tready", 32'(s_tready), 32'h0);
    chk("rst_eng_tvalid", 32'(eng_m.tvalid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_eng_tdata_zero", 32'(eng_m.tdata), 32'h0);
    chk("idle_s_tready", 32'(s_tready), 32'h0);

    // Channel 0 wins the simultaneous request and sends 64 beats
    @(negedge clk);
    #1;
    chk("ch0_grant", 32'(grant), 32'h1);
    chk("ch0_busy", 32'(busy), 32'h1);
    errs = 0;
    for (int k = 0; k < 64; k++) begin
      s_tdata[0] = msg0(k);
      s_tlast[0] = (k == 63);
      s_tuser[0] = k[0];
      #1;
      if (eng_m.tdata !== msg0(k) || eng_m.tvalid !== 1'b1 || eng_m.tlast !== (k == 63) ||
          eng_m.tuser !== k[0] || s_tready !== 2'b01)
        errs++;
      @(negedge clk);
    end
    chk("ch0_fwd_errs", 32'(errs), 32'h0);

    // Drain: channel 1 keeps requesting but must be held off
    s_tvalid[0] = 1'b0;
    s_tlast[0]  = 1'b0;
    #1;
    chk("drain_s1_tready", 32'(s_tready[1]), 32'h0);
    chk("drain_eng_tvalid", 32'(eng_m.tvalid), 32'h0);
    chk("drain_grant", 32'(grant), 32'h1);

    // 16 result beats with requester back-pressure toggling every cycle
    j = 0; errs = 0; cyc = 0; t = 1'b1;
    while (j < 16 && cyc < 100) begin
      m_tready[0] = t;
      e_vld  = 1'b1;
      e_dat  = ret0(j);
      e_last = (j == 15);
      #1;
      if (eng_s.tready !== t) errs++;
      if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== ret0(j) || m_tlast[0] !== (j == 15)) errs++;
      if (m_tvalid[1] !== 1'b0 || m_tdata[1] !== '0) errs++;
      if (s_tready !== 2'b00 || eng_m.tvalid !== 1'b0) errs++;
      if (m_tvalid[0] && m_tready[0]) begin
        got.push_back(m_tdata[0]);
        j++;
      end
      t = ~t;
      cyc++;
      @(negedge clk);
    end
    chk("ret_beat_count", 32'(got.size()), 32'd16);
    chk("ret_path_errs", 32'(errs), 32'h0);
    derr = 0;
    foreach (got[i]) if (got[i] !== ret0(i)) derr++;
    chk("ret_data_errs", 32'(derr), 32'h0);

    e_vld = 1'b0; e_last = 1'b0; m_tready = '0;
    #1;
    chk("rel_grant", 32'(grant), 32'h0);
    chk("rel_busy", 32'(busy), 32'h0);
`ifdef AES_ARB_STATS_EN
    chk("msg_cnt0_after_msg", 32'(msg_cnt[0]), 32'h1);
`endif

    // Channel 1 granted the cycle after release; channel 0 re-requests meanwhile
    @(negedge clk);
    #1;
    chk("ch1_grant", 32'(grant), 32'h2);
    s_tvalid[0] = 1'b1;
    s_tdata[0]  = 8'h77;
    errs = 0;
    for (int k = 0; k < 4; k++) begin
      s_tdata[1] = W'(165 + k);
      s_tlast[1] = (k == 3);
      #1;
      if (eng_m.tdata !== W'(165 + k) || eng_m.tvalid !== 1'b1 || s_tready !== 2'b10) errs++;
      @(negedge clk);
    end
    chk("ch1_fwd_errs", 32'(errs), 32'h0);
    s_tvalid[1] = 1'b0;
    s_tlast[1]  = 1'b0;
    m_tready[1] = 1'b1;
    errs = 0;
    for (int k = 0; k < 2; k++) begin
      e_vld  = 1'b1;
      e_dat  = W'(80 + k);
      e_last = (k == 1);
      #1;
      if (m_tvalid[1] !== 1'b1 || m_tdata[1] !== W'(80 + k) || m_tvalid[0] !== 1'b0 ||
          s_tready[0] !== 1'b0)
        errs++;
      @(negedge clk);
    end
    chk("ch1_ret_errs", 32'(errs), 32'h0);
    e_vld = 1'b0; e_last = 1'b0; m_tready = '0;
    #1;
    chk("ch1_rel_grant", 32'(grant), 32'h0);
`ifdef AES_ARB_STATS_EN
    chk("msg_cnt1_after_msg", 32'(msg_cnt[1]), 32'h1);
`endif

    @(negedge clk);
    #1;
    chk("ch0_regrant", 32'(grant), 32'h1);
    chk("ch0_regrant_data", 32'(eng_m.tdata), 32'h77);

    // Engine returns tlast while the request is still in flight: arbiter must release
    m_tready[0] = 1'b1;
    e_vld  = 1'b1;
    e_last = 1'b1;
    e_dat  = 8'h99;
    #1;
    chk("proto_m_tdata", 32'(m_tdata[0]), 32'h99);
    @(negedge clk);
    e_vld = 1'b0; e_last = 1'b0;
    #1;
    chk("proto_rel_grant", 32'(grant), 32'h0);
    chk("proto_rel_busy", 32'(busy), 32'h0);
    @(negedge clk);
    #1;
    chk("ch0_grant_again", 32'(grant), 32'h1);

    // Asynchronous reset mid-forward
    @(negedge clk);
    e_vld = 1'b1;
    e_dat = 8'h3C;
    #1;
    chk("pre_rst_m_tvalid", 32'(m_tvalid), 32'h1);
    rst = 1'b1;
    #1;
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_s_tready", 32'(s_tready), 32'h0);
    chk("arst_eng_tvalid", 32'(eng_m.tvalid), 32'h0);
    chk("arst_m_tvalid", 32'(m_tvalid), 32'h0);
    chk("arst_eng_s_tready", 32'(eng_s.tready), 32'h0);
`ifdef AES_ARB_STATS_EN
    chk("arst_msg_cnt0", 32'(msg_cnt[0]), 32'h0);
`endif

    // Pointer back at NUM_CH-1: channel 0 must win a tie again
    @(negedge clk);
    rst   = 1'b0;
    e_vld = 1'b0;
    m_tready = '0;
    s_tvalid = 2'b11;
    @(negedge clk);
    #1;
    chk("post_rst_grant", 32'(grant), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
